// File: rtl/pc_unit.sv
`timescale 1ns/1ps
// pc_unit: RV32 fetch-stage program counter with stall, prioritised
// trap/branch redirects, redirect capture across stalls, target alignment
// checking, a valid/ready fetch handshake and a retired-fetch counter.
module pc_unit #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              INC          = 4,
  parameter int              ALIGN_BITS   = 2,
  parameter int              CNT_W        = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             STALL,
  input  logic             BR_EN,
  input  logic [XLEN-1:0]  BR_TARGET,
  input  logic             TRAP_EN,
  input  logic [XLEN-1:0]  TRAP_VEC,
  input  logic             READY,
  output logic             VALID,
  output logic [XLEN-1:0]  Q,
  output logic [XLEN-1:0]  Q_PLUS,
  output logic             MISALIGN,
  output logic [CNT_W-1:0] FCNT
);

  // Low target bits that must be clear; all-zero mask when checking is off.
  localparam logic [XLEN-1:0] AMASK = XLEN'((64'd1 << ALIGN_BITS) - 64'd1);

  // Redirect priority levels: larger wins.
  localparam logic [1:0] PRI_NONE = 2'd0;
  localparam logic [1:0] PRI_BR   = 2'd1;
  localparam logic [1:0] PRI_TRAP = 2'd2;

  typedef enum logic [1:0] {BOOT, RUN, PEND} state_t;

  state_t          state, state_nx;
  logic [1:0]      pend_pri, pend_pri_nx;
  logic [XLEN-1:0] pend_tgt, pend_tgt_nx;
  logic            pend_mis, pend_mis_nx;
  logic [XLEN-1:0] q_nx;
  logic            mis_nx;

  logic [1:0]      new_pri;
  logic [XLEN-1:0] new_tgt;
  logic            new_mis;
  logic            br_mis;
  logic            take_new;
  logic [1:0]      sel_pri;
  logic [XLEN-1:0] sel_tgt;
  logic            sel_mis;
  logic            fire;

  assign Q_PLUS = Q + XLEN'(INC);
  assign VALID  = (state == RUN) && !STALL;
  assign fire   = VALID && READY;
  assign br_mis = |(BR_TARGET & AMASK);

  // Resolve this cycle's redirect request and arbitrate it against any
  // redirect still pending from a stall (newest wins on equal priority).
  always_comb begin
    new_pri = PRI_NONE;
    new_tgt = BR_TARGET;
    new_mis = 1'b0;
    if (TRAP_EN) begin
      new_pri = PRI_TRAP;
      new_tgt = TRAP_VEC;
    end else if (BR_EN) begin
      new_pri = PRI_BR;
      new_tgt = br_mis ? TRAP_VEC : BR_TARGET;
      new_mis = br_mis;
    end
    take_new = (new_pri != PRI_NONE) && (new_pri >= pend_pri);
    sel_pri  = take_new ? new_pri : pend_pri;
    sel_tgt  = take_new ? new_tgt : pend_tgt;
    sel_mis  = take_new ? new_mis : pend_mis;
  end

  // Next state: a stall parks the winning redirect, otherwise it is applied
  // ahead of the sequential increment.
  always_comb begin
    state_nx    = RUN;
    pend_pri_nx = PRI_NONE;
    pend_tgt_nx = pend_tgt;
    pend_mis_nx = 1'b0;
    q_nx        = Q;
    mis_nx      = 1'b0;
    if (STALL) begin
      pend_pri_nx = sel_pri;
      pend_tgt_nx = sel_tgt;
      pend_mis_nx = sel_mis;
      state_nx    = (sel_pri != PRI_NONE) ? PEND : RUN;
    end else if (sel_pri != PRI_NONE) begin
      q_nx   = sel_tgt;
      mis_nx = sel_mis;
    end else if (fire) begin
      q_nx = Q_PLUS;
    end
  end

  // State register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= BOOT;
    else      state <= state_nx;
  end

  // PC, pending redirect, misalign pulse and fetch counter.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      Q        <= RESET_VECTOR;
      pend_pri <= PRI_NONE;
      pend_tgt <= '0;
      pend_mis <= 1'b0;
      MISALIGN <= 1'b0;
      FCNT     <= '0;
    end else begin
      Q        <= q_nx;
      pend_pri <= pend_pri_nx;
      pend_tgt <= pend_tgt_nx;
      pend_mis <= pend_mis_nx;
      MISALIGN <= mis_nx;
      if (fire) FCNT <= FCNT + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
`timescale 1ns/1ps
// Bench for pc_unit: directed vector table, async-reset sequence, random
// run against a queue-based reference model, and a narrow 16-bit instance
// for wrap and disabled alignment checking.
module tb_pc_unit;

  logic        CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        RST, STALL, BR_EN, TRAP_EN, READY;
  logic [31:0] BR_TARGET, TRAP_VEC;
  logic        VALID, MISALIGN;
  logic [31:0] Q, Q_PLUS, FCNT;

  logic        r2, s2, b2, t2, rdy2;
  logic [15:0] bt2, tv2;
  logic        v2, m2;
  logic [15:0] q2, qp2;
  logic [7:0]  f2;

  pc_unit dut (
    .CLK(CLK), .RST(RST), .STALL(STALL), .BR_EN(BR_EN), .BR_TARGET(BR_TARGET),
    .TRAP_EN(TRAP_EN), .TRAP_VEC(TRAP_VEC), .READY(READY), .VALID(VALID),
    .Q(Q), .Q_PLUS(Q_PLUS), .MISALIGN(MISALIGN), .FCNT(FCNT)
  );

  pc_unit #(.XLEN(16), .RESET_VECTOR(16'hFFF4), .INC(4), .ALIGN_BITS(0), .CNT_W(8)) dut16 (
    .CLK(CLK), .RST(r2), .STALL(s2), .BR_EN(b2), .BR_TARGET(bt2),
    .TRAP_EN(t2), .TRAP_VEC(tv2), .READY(rdy2), .VALID(v2),
    .Q(q2), .Q_PLUS(qp2), .MISALIGN(m2), .FCNT(f2)
  );

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  task automatic drive(input logic s, input logic b, input logic [31:0] bt,
                       input logic t, input logic [31:0] tv, input logic r);
    STALL = s; BR_EN = b; BR_TARGET = bt; TRAP_EN = t; TRAP_VEC = tv; READY = r;
  endtask

  // Directed vectors: inputs held for one cycle, expected outputs during it.
  typedef struct {
    logic s, b; logic [31:0] bt; logic t; logic [31:0] tv; logic r;
    logic [31:0] eq; logic ev; logic [31:0] ef; logic em;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(input logic s, input logic b, input logic [31:0] bt,
                              input logic t, input logic [31:0] tv, input logic r,
                              input logic [31:0] eq, input logic ev,
                              input logic [31:0] ef, input logic em);
    vec_t v;
    v.s = s; v.b = b; v.bt = bt; v.t = t; v.tv = tv; v.r = r;
    v.eq = eq; v.ev = ev; v.ef = ef; v.em = em;
    tbl.push_back(v);
  endfunction

  // Reference model: redirects seen while stalled are queued and the best
  // one (highest priority, latest among equals) is applied on release.
  typedef struct { int pri; logic [31:0] tgt; bit mis; } redir_t;
  redir_t      pq[$];
  logic [31:0] m_q, m_fcnt;
  bit          m_boot, m_mis;

  function automatic bit m_valid();
    return !m_boot && !STALL && pq.size() == 0;
  endfunction

  function automatic void m_reset();
    m_q = 32'h0; m_fcnt = 0; m_boot = 1; m_mis = 0; pq.delete();
  endfunction

  function automatic void m_step();
    redir_t r;
    bit     fetch;
    fetch = m_valid() && READY;
    if (TRAP_EN) begin
      r.pri = 2; r.tgt = TRAP_VEC; r.mis = 0; pq.push_back(r);
    end else if (BR_EN) begin
      r.pri = 1; r.mis = (BR_TARGET % 4) != 0;
      r.tgt = r.mis ? TRAP_VEC : BR_TARGET;
      pq.push_back(r);
    end
    m_mis = 0;
    if (!STALL) begin
      if (pq.size() != 0) begin
        r = pq[0];
        foreach (pq[i]) if (pq[i].pri >= r.pri) r = pq[i];
        m_q = r.tgt; m_mis = r.mis;
        pq.delete();
      end else if (fetch) begin
        m_q = m_q + 4;
      end
    end
    if (fetch) m_fcnt = m_fcnt + 1;
    m_boot = 0;
  endfunction

  initial begin
    logic [31:0] bt, tv;
    r2 = 0; s2 = 0; b2 = 0; t2 = 0; rdy2 = 0; bt2 = '0; tv2 = '0;
    RST = 0;
    drive(0, 0, 0, 0, 0, 1);

    // Reset state.
    repeat (2) @(posedge CLK);
    #1;
    @(negedge CLK);
    chk("rst_q", Q, 32'h0);
    chk("rst_valid", 32'(VALID), 32'h0);
    chk("rst_fcnt", FCNT, 32'h0);
    chk("rst_mis", 32'(MISALIGN), 32'h0);
    @(posedge CLK); #1;
    RST = 1;

    add(0,0,0,0,0,1,          32'h0,  0, 0, 0);
    add(0,0,0,0,0,1,          32'h0,  1, 0, 0);
    add(0,0,0,0,0,1,          32'h4,  1, 1, 0);
    add(0,0,0,0,0,1,          32'h8,  1, 2, 0);
    add(0,0,0,0,0,1,          32'hC,  1, 3, 0);
    add(0,1,32'h100,0,0,1,    32'h10, 1, 4, 0);
    add(0,1,32'h200,1,32'h80,1, 32'h100, 1, 5, 0);
    add(0,1,32'h102,0,32'h80,1, 32'h80, 1, 6, 0);
    add(0,0,0,0,0,1,          32'h80, 1, 7, 1);
    add(1,1,32'h200,0,0,1,    32'h84, 0, 8, 0);
    add(1,0,0,1,32'h80,1,     32'h84, 0, 8, 0);
    add(1,0,0,0,0,1,          32'h84, 0, 8, 0);
    add(0,0,0,0,0,1,          32'h84, 0, 8, 0);
    for (int i = 0; i < 5; i++) add(0,0,0,0,0,0, 32'h80, 1, 8, 0);
    add(0,0,0,0,0,1,          32'h80, 1, 8, 0);
    add(1,1,32'h206,0,32'h40,1, 32'h84, 0, 9, 0);
    add(0,0,0,0,0,1,          32'h84, 0, 9, 0);
    add(0,0,0,0,0,1,          32'h40, 1, 9, 1);
    add(1,1,32'h300,0,0,1,    32'h44, 0, 10, 0);
    add(0,1,32'h400,0,0,1,    32'h44, 0, 10, 0);
    add(0,0,0,0,0,1,          32'h400, 1, 10, 0);
    add(0,0,0,0,0,1,          32'h404, 1, 11, 0);

    foreach (tbl[i]) begin
      drive(tbl[i].s, tbl[i].b, tbl[i].bt, tbl[i].t, tbl[i].tv, tbl[i].r);
      @(negedge CLK);
      chk($sformatf("vec%0d_q", i), Q, tbl[i].eq);
      chk($sformatf("vec%0d_qplus", i), Q_PLUS, tbl[i].eq + 32'd4);
      chk($sformatf("vec%0d_valid", i), 32'(VALID), 32'(tbl[i].ev));
      chk($sformatf("vec%0d_fcnt", i), FCNT, tbl[i].ef);
      chk($sformatf("vec%0d_mis", i), 32'(MISALIGN), 32'(tbl[i].em));
      @(posedge CLK); #1;
    end

    // Async reset while a redirect is parked.
    drive(1, 1, 32'h500, 0, 0, 1);
    @(posedge CLK); #1;
    drive(1, 0, 0, 0, 0, 1);
    #2;
    RST = 0;
    #1;
    chk("arst_q", Q, 32'h0);
    chk("arst_fcnt", FCNT, 32'h0);
    chk("arst_valid", 32'(VALID), 32'h0);
    @(posedge CLK); #1;
    RST = 1;
    drive(0, 0, 0, 0, 0, 1);
    @(negedge CLK);
    chk("arst_boot_valid", 32'(VALID), 32'h0);
    chk("arst_boot_q", Q, 32'h0);
    @(posedge CLK); #1;
    @(negedge CLK);
    chk("arst_run_valid", 32'(VALID), 32'h1);
    chk("arst_run_q", Q, 32'h0);
    @(posedge CLK); #1;
    @(negedge CLK);
    chk("arst_nostale_q", Q, 32'h4);
    chk("arst_nostale_fcnt", FCNT, 32'h1);
    @(posedge CLK); #1;

    // Random run against the reference model.
    RST = 0;
    @(posedge CLK); #1;
    RST = 1;
    m_reset();
    for (int c = 0; c < 1500; c++) begin
      bt = $urandom;
      if ($urandom_range(0, 3) != 0) bt[1:0] = 2'b00;
      tv = $urandom & 32'hFFFF_FFFC;
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, bt,
            $urandom_range(0, 15) == 0, tv, $urandom_range(0, 3) != 0);
      @(negedge CLK);
      chk("rnd_q", Q, m_q);
      chk("rnd_qplus", Q_PLUS, m_q + 32'd4);
      chk("rnd_valid", 32'(VALID), 32'(m_valid()));
      chk("rnd_fcnt", FCNT, m_fcnt);
      chk("rnd_mis", 32'(MISALIGN), 32'(m_mis));
      m_step();
      @(posedge CLK); #1;
    end
    drive(0, 0, 0, 0, 0, 0);

    // Narrow instance: PC wrap, no alignment check, counter wrap.
    chk("w16_rst_q", 32'(q2), 32'hFFF4);
    r2 = 1; rdy2 = 1;
    @(negedge CLK);
    chk("w16_boot_valid", 32'(v2), 32'h0);
    @(posedge CLK); #1;
    @(negedge CLK);
    chk("w16_q0", 32'(q2), 32'hFFF4);
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    @(negedge CLK);
    chk("w16_q_fffc", 32'(q2), 32'hFFFC);
    chk("w16_qplus_wrap", 32'(qp2), 32'h0000);
    @(posedge CLK); #1;
    b2 = 1; bt2 = 16'h0102;
    @(negedge CLK);
    chk("w16_q_wrapped", 32'(q2), 32'h0000);
    chk("w16_fcnt3", 32'(f2), 32'h3);
    @(posedge CLK); #1;
    b2 = 0;
    @(negedge CLK);
    chk("w16_br_unaligned_ok", 32'(q2), 32'h0102);
    chk("w16_no_mis", 32'(m2), 32'h0);
    for (int c = 0; c < 260; c++) begin
      @(posedge CLK); #1;
    end
    @(negedge CLK);
    chk("w16_fcnt_wrap", 32'(f2), 32'h8);
    chk("w16_q_after", 32'(q2), 32'h0512);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
